// File: rtl/vga_text_gen.sv
// vga_text_gen -- pixel-stage text renderer for an 800x600 boot screen.
//
// Sits directly behind the VGA sync generator. It rebuilds the pixel and
// line position from hs/vs/de, fetches a char+attribute word from text VRAM,
// fetches the glyph row from the font ROM and produces 24-bit RGB. The sync
// signals are delayed so they stay aligned with the colour output.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   hs_in, vs_in, de_in   sync/enable from the sync generator
//   vram_addr, vram_data  text VRAM (sync read, 1 clk latency)
//                         data[7:0] = char code, data[15:8] = attribute
//   font_addr, font_data  font ROM {char, cell_row}, glyph row bit7 = left
//   cursor_en/col/row     block cursor, blinks on frame_cnt[4], rows 14-15
//   hs_out, vs_out,       inputs delayed 5 clk
//   de_out
//   r, g, b               colour, changes on the same edge as de_out
//
// Pipeline (E0 = edge that samples de_in for a pixel):
//   E0 address VRAM, E1 VRAM read, E2 address font, E3 font read,
//   E4 colour select and output register.
module vga_text_gen #(
  parameter int COLS   = 100,
  parameter int ROWS   = 37,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [11:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam logic [6:0]  COLS_C   = 7'(COLS);
  localparam logic [5:0]  ROWS_C   = 6'(ROWS);
  localparam logic [11:0] ROW_STEP = 12'(COLS);

  // Position state
  logic [9:0]  px;
  logic [6:0]  col;
  logic [3:0]  ln;
  logic [5:0]  row;
  logic [11:0] row_base;
  logic [5:0]  frame_cnt;
  logic        de_prev;
  logic        vs_prev;

  logic vs_edge;
  logic line_end;
  logic cursor_hit;

  assign vs_edge    = (vs_in == VS_POL) && (vs_prev != VS_POL);
  assign line_end   = de_prev && !de_in;
  // Cursor decision is taken with the cell position of this pixel and then
  // carried down the pipeline as one bit.
  assign cursor_hit = cursor_en && frame_cnt[4] && (row == cursor_row) &&
                      (col == cursor_col) && (ln >= 4'd14);

  always_ff @(posedge clk) begin
    if (reset) begin
      px        <= '0;
      col       <= '0;
      ln        <= '0;
      row       <= '0;
      row_base  <= '0;
      frame_cnt <= '0;
      de_prev   <= 1'b0;
      vs_prev   <= ~VS_POL;
    end else begin
      de_prev <= de_in;
      vs_prev <= vs_in;
      if (de_in) begin
        px <= px + 10'd1;
        if (px[2:0] == 3'd7) col <= col + 7'd1;
      end else begin
        px  <= '0;
        col <= '0;
      end
      // A vs edge landing on the same clock as a line end wins.
      if (vs_edge) begin
        ln        <= '0;
        row       <= '0;
        row_base  <= '0;
        frame_cnt <= frame_cnt + 6'd1;
      end else if (line_end) begin
        ln <= ln + 4'd1;
        if (ln == 4'd15) begin
          row      <= row + 6'd1;
          row_base <= row_base + ROW_STEP;
        end
      end
    end
  end

  // Sideband carried alongside the memory fetches
  logic [2:0] s1_px, s2_px, s3_px, s4_px;
  logic [3:0] s1_ln, s2_ln;
  logic       s1_rng, s2_rng, s3_rng, s4_rng;
  logic       s1_cur, s2_cur, s3_cur, s4_cur;
  logic [7:0] s3_attr, s4_attr;
  logic [4:0] hs_sr, vs_sr, de_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= '0;
      font_addr <= '0;
      s1_px <= '0; s2_px <= '0; s3_px <= '0; s4_px <= '0;
      s1_ln <= '0; s2_ln <= '0;
      s1_rng <= 1'b0; s2_rng <= 1'b0; s3_rng <= 1'b0; s4_rng <= 1'b0;
      s1_cur <= 1'b0; s2_cur <= 1'b0; s3_cur <= 1'b0; s4_cur <= 1'b0;
      s3_attr <= '0; s4_attr <= '0;
      hs_sr <= {5{~HS_POL}};
      vs_sr <= {5{~VS_POL}};
      de_sr <= '0;
    end else begin
      // E0
      vram_addr <= row_base + {5'd0, col};
      s1_px     <= px[2:0];
      s1_ln     <= ln;
      s1_rng    <= (col < COLS_C) && (row < ROWS_C);
      s1_cur    <= cursor_hit;
      // E1 (VRAM read in flight)
      s2_px  <= s1_px;
      s2_ln  <= s1_ln;
      s2_rng <= s1_rng;
      s2_cur <= s1_cur;
      // E2
      font_addr <= {vram_data[7:0], s2_ln};
      s3_attr   <= vram_data[15:8];
      s3_px     <= s2_px;
      s3_rng    <= s2_rng;
      s3_cur    <= s2_cur;
      // E3 (font read in flight)
      s4_attr <= s3_attr;
      s4_px   <= s3_px;
      s4_rng  <= s3_rng;
      s4_cur  <= s3_cur;
      // Sync delay line; de_sr[3] is this pixel's de at E4
      hs_sr <= {hs_sr[3:0], hs_in};
      vs_sr <= {vs_sr[3:0], vs_in};
      de_sr <= {de_sr[3:0], de_in};
    end
  end

  assign hs_out = hs_sr[4];
  assign vs_out = vs_sr[4];
  assign de_out = de_sr[4];

  // E4 colour select. Colour nibble is IRGB: [3]=I, [2]=R, [1]=G, [0]=B.
  logic       pix;
  logic [3:0] colour;
  logic       active;

  always_comb begin
    pix    = font_data[~s4_px];
    colour = 4'd0;
    if (s4_cur) colour = pix ? s4_attr[7:4] : s4_attr[3:0];
    else        colour = pix ? s4_attr[3:0] : s4_attr[7:4];
    active = de_sr[3] && s4_rng;
  end

  function automatic logic [7:0] level(input logic on, input logic inten);
    if (on) return inten ? 8'hFF : 8'hAA;
    else    return inten ? 8'h55 : 8'h00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= level(colour[2], colour[3]);
      g <= level(colour[1], colour[3]);
      b <= level(colour[0], colour[3]);
    end
  end

endmodule

// File: tb/tb_vga_text_gen.sv
// Directed bench for vga_text_gen. The bench plays the sync generator with
// short lines, models the VRAM and font ROM as 1-clk synchronous memories
// and logs every output after each clock so scenarios can inspect exact
// pipeline positions. A pixel driven on tick n addresses VRAM at log n and
// shows its colour at log n+4.
module tb_vga_text_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        hs_in = 1'b0, vs_in = 1'b0, de_in = 1'b0;
  logic [11:0] vram_addr, font_addr;
  logic [15:0] vram_data;
  logic [7:0]  font_data;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [5:0]  cursor_row = '0;
  logic        hs_out, vs_out, de_out;
  logic [7:0]  r, g, b;

  vga_text_gen dut (
    .clk(clk), .reset(reset),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .r(r), .g(g), .b(b)
  );

  // Memory models
  logic [15:0] vram [4096];
  logic [7:0]  font [4096];
  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLUE  = 24'h0000AA;
  localparam logic [23:0] BLACK = 24'h000000;

  // Output / input log, ring of 8192 ticks
  localparam int MSK = 8191;
  logic [23:0] rgb_log [8192];
  logic        de_log [8192], hs_log [8192], vs_log [8192];
  logic [11:0] va_log [8192], fa_log [8192];
  logic        hin_log [8192], vin_log [8192], din_log [8192];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  function automatic int ix(input int n);
    return n & MSK;
  endfunction

  // Clock/drive block
  task automatic tick(input logic h, input logic v, input logic d);
    hs_in = h; vs_in = v; de_in = d;
    @(posedge clk);
    #1;
    cyc++;
    hin_log[ix(cyc)] = h;
    vin_log[ix(cyc)] = v;
    din_log[ix(cyc)] = d;
    rgb_log[ix(cyc)] = {r, g, b};
    de_log[ix(cyc)]  = de_out;
    hs_log[ix(cyc)]  = hs_out;
    vs_log[ix(cyc)]  = vs_out;
    va_log[ix(cyc)]  = vram_addr;
    fa_log[ix(cyc)]  = font_addr;
  endtask

  task automatic drive_line(input int npix, output int start);
    start = cyc + 1;
    for (int i = 0; i < npix; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic draw_lines(input int n, input int npix);
    int s;
    for (int i = 0; i < n; i++) drive_line(npix, s);
  endtask

  task automatic vs_pulse();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({hs_out, vs_out, de_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_sync tick %0d: got %b, want 000", i, {hs_out, vs_out, de_out});
      end
      n_cmp++;
      if ({r, g, b} !== BLACK) begin
        n_fail++;
        $display("FAIL reset_rgb tick %0d: got %h, want 000000", i, {r, g, b});
      end
      n_cmp++;
      if (vram_addr !== 12'h000 || font_addr !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_addr tick %0d: got va=%h fa=%h, want 000/000", i, vram_addr, font_addr);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_first_pixel();
    int s;
    vs_pulse();
    drive_line(16, s);
    n_cmp++;
    if (va_log[ix(s)] !== 12'h000) begin
      n_fail++;
      $display("FAIL first_vram_addr: got %h, want 000", va_log[ix(s)]);
    end
    n_cmp++;
    if (fa_log[ix(s + 2)] !== 12'h410) begin
      n_fail++;
      $display("FAIL first_font_addr: got %h, want 410", fa_log[ix(s + 2)]);
    end
    n_cmp++;
    if (de_log[ix(s + 3)] !== 1'b0 || de_log[ix(s + 4)] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_de_latency: got %b%b, want 01", de_log[ix(s + 3)], de_log[ix(s + 4)]);
    end
    n_cmp++;
    if (rgb_log[ix(s + 4)] !== WHITE) begin
      n_fail++;
      $display("FAIL first_px0: got %h, want FFFFFF", rgb_log[ix(s + 4)]);
    end
    for (int p = 1; p < 8; p++) begin
      n_cmp++;
      if (rgb_log[ix(s + 4 + p)] !== BLUE) begin
        n_fail++;
        $display("FAIL first_px%0d: got %h, want 0000AA", p, rgb_log[ix(s + 4 + p)]);
      end
    end
  endtask

  task automatic test_addressing();
    int s;
    draw_lines(15, 16);
    drive_line(16, s);
    n_cmp++;
    if (va_log[ix(s)] !== 12'd100) begin
      n_fail++;
      $display("FAIL addr_line16: got %0d, want 100", va_log[ix(s)]);
    end
    draw_lines(15, 16);
    drive_line(48, s);
    n_cmp++;
    if (va_log[ix(s)] !== 12'd200) begin
      n_fail++;
      $display("FAIL addr_line32_px0: got %0d, want 200", va_log[ix(s)]);
    end
    n_cmp++;
    if (va_log[ix(s + 40)] !== 12'd205) begin
      n_fail++;
      $display("FAIL addr_line32_px40: got %0d, want 205", va_log[ix(s + 40)]);
    end
  endtask

  // Draws lines 0..31 of a frame with 32-pixel lines, returns line starts.
  task automatic cursor_frame(output int s16, output int s29, output int s30, output int s31);
    draw_lines(16, 32);
    drive_line(32, s16);
    draw_lines(12, 32);
    drive_line(32, s29);
    drive_line(32, s30);
    drive_line(32, s31);
  endtask

  task automatic test_cursor_on();
    int s16, s29, s30, s31;
    logic [23:0] e30 [8];
    cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 6'd1;
    repeat (15) vs_pulse();   // frame_cnt 1 -> 16
    cursor_frame(s16, s29, s30, s31);
    e30 = '{BLUE, BLUE, BLUE, BLUE, WHITE, WHITE, WHITE, WHITE};
    for (int p = 0; p < 8; p++) begin
      n_cmp++;
      if (rgb_log[ix(s16 + 16 + p + 4)] !== (p == 0 ? WHITE : BLUE)) begin
        n_fail++;
        $display("FAIL cur_on_line16 px%0d: got %h, want %h", 16 + p, rgb_log[ix(s16 + 16 + p + 4)], (p == 0 ? WHITE : BLUE));
      end
      n_cmp++;
      if (rgb_log[ix(s29 + 16 + p + 4)] !== BLUE) begin
        n_fail++;
        $display("FAIL cur_on_line29 px%0d: got %h, want 0000AA", 16 + p, rgb_log[ix(s29 + 16 + p + 4)]);
      end
      n_cmp++;
      if (rgb_log[ix(s30 + 16 + p + 4)] !== e30[p]) begin
        n_fail++;
        $display("FAIL cur_on_line30 px%0d: got %h, want %h", 16 + p, rgb_log[ix(s30 + 16 + p + 4)], e30[p]);
      end
      n_cmp++;
      if (rgb_log[ix(s31 + 16 + p + 4)] !== WHITE) begin
        n_fail++;
        $display("FAIL cur_on_line31 px%0d: got %h, want FFFFFF", 16 + p, rgb_log[ix(s31 + 16 + p + 4)]);
      end
    end
    n_cmp++;
    if (rgb_log[ix(s30 + 24 + 4)] !== BLACK) begin
      n_fail++;
      $display("FAIL cur_on_line30 px24: got %h, want 000000", rgb_log[ix(s30 + 24 + 4)]);
    end
  endtask

  task automatic test_cursor_off();
    int s16, s29, s30, s31;
    logic [23:0] e30 [8];
    repeat (16) vs_pulse();   // frame_cnt 16 -> 32, bit4 clear
    cursor_frame(s16, s29, s30, s31);
    e30 = '{WHITE, WHITE, WHITE, WHITE, BLUE, BLUE, BLUE, BLUE};
    for (int p = 0; p < 8; p++) begin
      n_cmp++;
      if (rgb_log[ix(s30 + 16 + p + 4)] !== e30[p]) begin
        n_fail++;
        $display("FAIL cur_off_line30 px%0d: got %h, want %h", 16 + p, rgb_log[ix(s30 + 16 + p + 4)], e30[p]);
      end
      n_cmp++;
      if (rgb_log[ix(s31 + 16 + p + 4)] !== BLUE) begin
        n_fail++;
        $display("FAIL cur_off_line31 px%0d: got %h, want 0000AA", 16 + p, rgb_log[ix(s31 + 16 + p + 4)]);
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    int s591, s592, s599, s;
    vram[3600] = 16'h1F41;
    vram[3700] = 16'h1F41;
    vram[3701] = 16'h1F41;
    vram[100]  = 16'h1F41;
    vs_pulse();
    draw_lines(591, 16);
    drive_line(16, s591);
    drive_line(16, s592);
    draw_lines(6, 16);
    drive_line(16, s599);
    n_cmp++;
    if (rgb_log[ix(s591 + 4)] !== BLUE) begin
      n_fail++;
      $display("FAIL row36_px0: got %h, want 0000AA", rgb_log[ix(s591 + 4)]);
    end
    for (int p = 0; p < 16; p++) begin
      n_cmp++;
      if (de_log[ix(s592 + p + 4)] !== 1'b1 || rgb_log[ix(s592 + p + 4)] !== BLACK) begin
        n_fail++;
        $display("FAIL row37_line592 px%0d: got de=%b rgb=%h, want de=1 rgb=000000", p, de_log[ix(s592 + p + 4)], rgb_log[ix(s592 + p + 4)]);
      end
    end
    n_cmp++;
    if (rgb_log[ix(s599 + 4)] !== BLACK) begin
      n_fail++;
      $display("FAIL row37_line599 px0: got %h, want 000000", rgb_log[ix(s599 + 4)]);
    end
    // Column 100 on row 0
    vs_pulse();
    drive_line(808, s);
    n_cmp++;
    if (rgb_log[ix(s + 4)] !== WHITE) begin
      n_fail++;
      $display("FAIL wide_px0: got %h, want FFFFFF", rgb_log[ix(s + 4)]);
    end
    n_cmp++;
    if (va_log[ix(s + 800)] !== 12'd100) begin
      n_fail++;
      $display("FAIL col100_addr: got %0d, want 100", va_log[ix(s + 800)]);
    end
    for (int p = 800; p < 808; p++) begin
      n_cmp++;
      if (de_log[ix(s + p + 4)] !== 1'b1 || rgb_log[ix(s + p + 4)] !== BLACK) begin
        n_fail++;
        $display("FAIL col100 px%0d: got de=%b rgb=%h, want de=1 rgb=000000", p, de_log[ix(s + p + 4)], rgb_log[ix(s + p + 4)]);
      end
    end
  endtask

  task automatic test_vs_line_end();
    int s;
    vs_pulse();
    draw_lines(5, 16);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);   // de falls and vs rises on the same edge
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    drive_line(16, s);
    n_cmp++;
    if (va_log[ix(s)] !== 12'h000) begin
      n_fail++;
      $display("FAIL vs_wins_addr: got %h, want 000", va_log[ix(s)]);
    end
    n_cmp++;
    if (fa_log[ix(s + 2)] !== 12'h410) begin
      n_fail++;
      $display("FAIL vs_wins_font_addr: got %h, want 410", fa_log[ix(s + 2)]);
    end
    n_cmp++;
    if (rgb_log[ix(s + 4)] !== WHITE) begin
      n_fail++;
      $display("FAIL vs_wins_px0: got %h, want FFFFFF", rgb_log[ix(s + 4)]);
    end
  endtask

  task automatic test_sync_delay();
    int s;
    s = cyc + 1;
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int n = s; n < s + 396; n++) begin
      n_cmp++;
      if ({hs_log[ix(n + 4)], vs_log[ix(n + 4)], de_log[ix(n + 4)]} !==
          {hin_log[ix(n)], vin_log[ix(n)], din_log[ix(n)]}) begin
        n_fail++;
        $display("FAIL sync_delay tick %0d: got hvd=%b%b%b, want %b%b%b", n - s,
                 hs_log[ix(n + 4)], vs_log[ix(n + 4)], de_log[ix(n + 4)],
                 hin_log[ix(n)], vin_log[ix(n)], din_log[ix(n)]);
      end
      if (din_log[ix(n)] == 1'b0) begin
        n_cmp++;
        if (rgb_log[ix(n + 4)] !== BLACK) begin
          n_fail++;
          $display("FAIL blank_rgb tick %0d: got %h, want 000000", n - s, rgb_log[ix(n + 4)]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vram[i] = 16'h0000;
      font[i] = 8'h00;
    end
    vram[0]     = 16'h1F41;
    vram[102]   = 16'h1F41;
    font[12'h410] = 8'h80;
    font[12'h41E] = 8'hF0;

    test_reset();
    test_first_pixel();
    test_addressing();
    test_cursor_on();
    test_cursor_off();
    test_out_of_range();
    test_vs_line_end();
    test_sync_delay();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_gen.md
Name: vga_text_gen

Overview:
- Pixel-stage text renderer sitting directly downstream of the boot-screen VGA sync generator.
- Consumes the generator's hs/vs/de and rebuilds pixel/line position from them.
- Fetches character+attribute words from an external text VRAM and glyph rows from an external font ROM, producing 24-bit RGB.
- Delays hs/vs/de to stay aligned with the RGB output. Target mode is 800x600 with 8x16 cells (100x37 text grid).

Parameters:
COLS, 100, text columns per row
ROWS, 37, text rows per screen
HS_POL, 1, active level of hs_in/hs_out
VS_POL, 1, active level of vs_in/vs_out

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous active-high reset
hs_in  in  1  hsync from sync generator
vs_in  in  1  vsync from sync generator
de_in  in  1  display enable from sync generator
vram_addr  out  12  text VRAM word address
vram_data  in  16  [7:0] char code, [15:8] attribute; sync RAM, 1-cycle read latency
font_addr  out  12  {char[7:0], cell_row[3:0]}
font_data  in  8  glyph row, bit7 = leftmost pixel; sync ROM, 1-cycle read latency
cursor_en  in  1  cursor enable
cursor_col  in  7  cursor column
cursor_row  in  6  cursor row
hs_out  out  1  hs_in delayed 5 clk
vs_out  out  1  vs_in delayed 5 clk
de_out  out  1  de_in delayed 5 clk
r, g, b  out  8 each  pixel colour, aligned with de_out

Behaviour:
- Position tracking, edge E0 = edge that samples de_in for a pixel:
  - px (10b) increments while de_in=1; cleared when de_in=0.
  - col (7b) increments when px[2:0]==7; cleared with px.
  - Line end = de falling edge (de_prev=1, de_in=0). At line end, ln (4b, cell row) increments modulo 16.
  - When ln wraps 15->0 at line end: row (6b) increments and row_base (12b) += COLS.
  - vs_in transition to VS_POL level: ln, row, row_base cleared to 0; frame_cnt (6b) increments, wrapping.
- Pipeline, one clock per stage:
  - E0: vram_addr <= row_base + col. Register in_range = (col<COLS && row<ROWS), px[2:0], ln, row, col.
  - E2: sample vram_data. font_addr <= {char, ln}. Register attr and sideband.
  - E4: sample font_data. pix = font_data[7 - px[2:0]].
  - E4 colour select: fg = attr[3:0], bg = attr[7:4] (IRGB).
  - Cursor: if cursor_en && frame_cnt[4] && row==cursor_row && col==cursor_col && ln>=14, swap fg/bg.
  - Colour register: colour = pix ? fg : bg. Each channel = R/G/B bit ? (I ? FF : AA) : (I ? 55 : 00).
  - Force rgb = 0 if delayed de=0 or in_range=0.
  - hs/vs/de pass through a 5-deep shift register; r/g/b change on the same edge as de_out.
- Out-of-range cells (col>=COLS, row>=ROWS) output black with de_out still 1. vram_addr is still driven there but its data is ignored.
- Reset:
  - px/col/ln/row/row_base/frame_cnt = 0; all pipeline regs cleared.
  - hs_out = ~HS_POL, vs_out = ~VS_POL, de_out = 0, r/g/b = 0, vram_addr = 0, font_addr = 0.
- Reset mid-frame: resumes counting from row 0 at current line; picture is offset until the next vs edge, then correct. No other recovery.
- Simultaneous line end and vs edge on the same clock: vs clear wins.

Test Plan:
- Reset asserted for 3 clk while stimuli toggle -> hs_out=0, vs_out=0, de_out=0, rgb=000000, vram_addr=0, font_addr=0 throughout (POL=1).
- Frame start, pixel (0,0); VRAM[0]=0x1F41, font ROM[0x410]=0x80 -> vram_addr=0 after E0, font_addr=0x410. Five clk after de_in rises: de_out=1 and rgb=FFFFFF, then seven pixels 0000AA.
- Line 16, first pixel -> vram_addr=100 (0x064). Line 32, px=40 -> vram_addr=205 (0x0CD).
- Lines 592..599 (row 37) -> de_out=1, rgb=000000 for the whole line.
- cursor_en=1, cursor at (col 2, row 1), frame_cnt[4]=1, cell attr 0x1F -> lines 30-31, px 16-23 show fg/bg swapped. Lines 16-29 unchanged. frame_cnt[4]=0 -> no swap.
- Full 1056x628 frame from the sync generator -> hs_out/vs_out/de_out equal inputs delayed exactly 5 clk. frame_cnt +1 per frame; ln/row reset at each vs edge.
